// File: rtl/vdma_frame_addr_gen_if.sv
// Burst address channel from the VDMA frame address generator toward the AXI address stage.
// A transfer happens on each rising edge where addr_valid and addr_ready are both high; once raised, addr_valid, out_addr and addr_is_tail hold until that transfer, an abort or a reset.
interface vdma_frame_addr_gen_if #(
    parameter int ASIZE = 29
);
    logic [ASIZE-1:0] out_addr;
    logic             addr_valid;
    logic             addr_ready;
    logic             addr_is_tail;

    modport master (output out_addr, output addr_valid, output addr_is_tail, input addr_ready);
    modport slave  (input out_addr, input addr_valid, input addr_is_tail, output addr_ready);
endinterface

// File: rtl/vdma_frame_addr_gen.sv
// Walks a ring of frame buffers and issues one burst address per handshake:
// full bursts and an optional tail burst per line, lines advanced by a line stride.
module vdma_frame_addr_gen #(
    parameter int          ASIZE          = 29,
    parameter int unsigned BURST_MAP_ADDR = 12800,
    parameter int          NFRAMES        = 3,
    parameter int          FSIZE          = 2,
    parameter int          LSIZE          = 12,
    parameter int          BSIZE          = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  abort,
    input  logic [ASIZE-1:0]      frame_base,
    input  logic [ASIZE-1:0]      frame_stride,
    input  logic [ASIZE-1:0]      line_stride,
    input  logic [BSIZE-1:0]      bursts_per_line,
    input  logic                  tail_en,
    input  logic [LSIZE-1:0]      lines_per_frame,
    vdma_frame_addr_gen_if.master addr_if,
    output logic [FSIZE-1:0]      frame_idx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_drop,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FDONE = 2'd2
    } state_t;

    state_t           state;
    logic [ASIZE-1:0] frame_ptr;
    logic [ASIZE-1:0] line_base;
    logic [ASIZE-1:0] cfg_frame_base;
    logic [ASIZE-1:0] cfg_frame_stride;
    logic [ASIZE-1:0] cfg_line_stride;
    logic [BSIZE-1:0] cfg_bursts;
    logic             cfg_tail_en;
    logic [LSIZE-1:0] cfg_lines;
    logic [BSIZE-1:0] burst_cnt;
    logic [LSIZE-1:0] line_cnt;

    logic [ASIZE-1:0] start_ptr;
    logic             empty_cfg;
    logic             handshake;
    logic             last_full;
    logic             last_line;

    // Slot 0 always restarts from the live frame_base; other slots use the accumulated pointer.
    assign start_ptr = (frame_idx == '0) ? frame_base : frame_ptr;
    assign empty_cfg = (lines_per_frame == '0) || ((bursts_per_line == '0) && !tail_en);
    assign handshake = addr_if.addr_valid && addr_if.addr_ready;
    assign last_full = (burst_cnt == cfg_bursts - BSIZE'(1));
    assign last_line = (line_cnt == cfg_lines - LSIZE'(1));
    assign dbg_state = state;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            addr_if.out_addr     <= '0;
            addr_if.addr_valid   <= 1'b0;
            addr_if.addr_is_tail <= 1'b0;
            frame_idx            <= '0;
            busy                 <= 1'b0;
            frame_done           <= 1'b0;
            frame_drop           <= 1'b0;
            frame_ptr            <= '0;
            line_base            <= '0;
            cfg_frame_base       <= '0;
            cfg_frame_stride     <= '0;
            cfg_line_stride      <= '0;
            cfg_bursts           <= '0;
            cfg_tail_en          <= 1'b0;
            cfg_lines            <= '0;
            burst_cnt            <= '0;
            line_cnt             <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            if (abort) begin
                // Slot and pointer are left alone so the aborted slot is reused.
                state                <= IDLE;
                addr_if.addr_valid   <= 1'b0;
                addr_if.addr_is_tail <= 1'b0;
                busy                 <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_start) begin
                            cfg_frame_base       <= frame_base;
                            cfg_frame_stride     <= frame_stride;
                            cfg_line_stride      <= line_stride;
                            cfg_bursts           <= bursts_per_line;
                            cfg_tail_en          <= tail_en;
                            cfg_lines            <= lines_per_frame;
                            frame_ptr            <= start_ptr;
                            line_base            <= start_ptr;
                            addr_if.out_addr     <= start_ptr;
                            addr_if.addr_is_tail <= (bursts_per_line == '0);
                            burst_cnt            <= '0;
                            line_cnt             <= '0;
                            if (empty_cfg) begin
                                state <= FDONE;
                            end else begin
                                state              <= ISSUE;
                                busy               <= 1'b1;
                                addr_if.addr_valid <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        frame_drop <= frame_start;
                        if (handshake) begin
                            if (!addr_if.addr_is_tail && !last_full) begin
                                addr_if.out_addr <= addr_if.out_addr + ASIZE'(BURST_MAP_ADDR);
                                burst_cnt        <= burst_cnt + BSIZE'(1);
                            end else if (!addr_if.addr_is_tail && cfg_tail_en) begin
                                // Tail sits one burst past the last full burst: no multiply needed.
                                addr_if.out_addr     <= addr_if.out_addr + ASIZE'(BURST_MAP_ADDR);
                                addr_if.addr_is_tail <= 1'b1;
                            end else if (last_line) begin
                                addr_if.addr_valid   <= 1'b0;
                                addr_if.addr_is_tail <= 1'b0;
                                state                <= FDONE;
                            end else begin
                                line_base            <= line_base + cfg_line_stride;
                                addr_if.out_addr     <= line_base + cfg_line_stride;
                                addr_if.addr_is_tail <= (cfg_bursts == '0);
                                burst_cnt            <= '0;
                                line_cnt             <= line_cnt + LSIZE'(1);
                            end
                        end
                    end
                    FDONE: begin
                        frame_drop <= frame_start;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                        if (frame_idx == FSIZE'(NFRAMES - 1)) begin
                            frame_idx <= '0;
                            frame_ptr <= cfg_frame_base;
                        end else begin
                            frame_idx <= frame_idx + FSIZE'(1);
                            frame_ptr <= frame_ptr + cfg_frame_stride;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vdma_frame_addr_gen.sv
// Directed bench for vdma_frame_addr_gen: ring walk, backpressure, degenerate configs,
// collisions, abort, address wrap and asynchronous reset.
module tb_vdma_frame_addr_gen;

    localparam int ASIZE = 29;
    localparam int FSIZE = 2;
    localparam int LSIZE = 12;
    localparam int BSIZE = 8;

    // clock / reset
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic              frame_start = 1'b0;
    logic              abort = 1'b0;
    logic [ASIZE-1:0]  frame_base = '0;
    logic [ASIZE-1:0]  frame_stride = '0;
    logic [ASIZE-1:0]  line_stride = '0;
    logic [BSIZE-1:0]  bursts_per_line = '0;
    logic              tail_en = 1'b0;
    logic [LSIZE-1:0]  lines_per_frame = '0;
    logic [FSIZE-1:0]  frame_idx;
    logic              busy;
    logic              frame_done;
    logic              frame_drop;
    logic [1:0]        dbg_state;

    logic ready_drv = 1'b1;
    logic bp_mode = 1'b0;
    logic bp_ready = 1'b1;
    int   bp_phase = 0;

    vdma_frame_addr_gen_if #(.ASIZE(ASIZE)) bus ();
    assign bus.addr_ready = bp_mode ? bp_ready : ready_drv;

    vdma_frame_addr_gen #(
        .ASIZE(ASIZE), .BURST_MAP_ADDR(32'h100), .NFRAMES(3),
        .FSIZE(FSIZE), .LSIZE(LSIZE), .BSIZE(BSIZE)
    ) dut (
        .clock(clock), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
        .frame_base(frame_base), .frame_stride(frame_stride), .line_stride(line_stride),
        .bursts_per_line(bursts_per_line), .tail_en(tail_en), .lines_per_frame(lines_per_frame),
        .addr_if(bus.master), .frame_idx(frame_idx), .busy(busy),
        .frame_done(frame_done), .frame_drop(frame_drop), .dbg_state(dbg_state)
    );

    // scoreboard: expected {addr_is_tail, out_addr} per handshake
    logic [ASIZE:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic           stall_prev = 1'b0;
    logic [ASIZE:0] held = '0;
    always @(negedge clock) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && bus.addr_valid)
                check("stall_hold", 32'({bus.addr_is_tail, bus.out_addr}), 32'(held));
            if (bus.addr_valid && bus.addr_ready) begin
                hs_count++;
                if (exp_q.size() == 0)
                    check("extra_addr", 32'(exp_q.size()), 32'd1);
                else
                    check("addr", 32'({bus.addr_is_tail, bus.out_addr}), 32'(exp_q.pop_front()));
            end
            stall_prev = bus.addr_valid && !bus.addr_ready;
            held = {bus.addr_is_tail, bus.out_addr};
        end
    end

    // ready pattern 1,0,0,1 repeating while in backpressure mode
    always @(posedge clock) begin
        #1;
        if (bp_mode) begin
            bp_ready = ((bp_phase % 4) == 0) || ((bp_phase % 4) == 3);
            bp_phase++;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        abort = 1'b0;
        ready_drv = 1'b1;
        bp_mode = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input logic [ASIZE-1:0] base, input logic [BSIZE-1:0] bursts,
                           input logic tail, input logic [LSIZE-1:0] lines);
        frame_base = base;
        frame_stride = 29'h40000;
        line_stride = 29'h1000;
        bursts_per_line = bursts;
        tail_en = tail;
        lines_per_frame = lines;
    endtask

    task automatic push(input logic tail, input logic [ASIZE-1:0] a);
        exp_q.push_back({tail, a});
    endtask

    // bursts=2, tail on, two lines, line stride 0x1000, burst step 0x100
    task automatic push_frame(input logic [ASIZE-1:0] b);
        push(1'b0, b);
        push(1'b0, b + 29'h100);
        push(1'b1, b + 29'h200);
        push(1'b0, b + 29'h1000);
        push(1'b0, b + 29'h1100);
        push(1'b1, b + 29'h1200);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        logic found;
        found = 1'b0;
        cycles = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clock);
            if (frame_done) begin
                found = 1'b1;
                cycles = i;
            end
        end
        check("done_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [ASIZE-1:0] ring_base [4];
        logic [FSIZE-1:0] ring_idx [4];
        ring_base = '{29'h10000, 29'h50000, 29'h90000, 29'h10000};
        ring_idx = '{2'd0, 2'd1, 2'd2, 2'd0};

        // reset values
        repeat (2) @(negedge clock);
        check("rst_valid", 32'(bus.addr_valid), 32'd0);
        check("rst_addr", 32'(bus.out_addr), 32'd0);
        check("rst_tail", 32'(bus.addr_is_tail), 32'd0);
        check("rst_idx", 32'(frame_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_drop", 32'(frame_drop), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // basic walk
        apply_reset();
        set_cfg(29'h10000, 8'd2, 1'b1, 12'd2);
        push_frame(29'h10000);
        hs_count = 0;
        pulse_start();
        @(negedge clock);
        check("basic_first_valid", 32'(bus.addr_valid), 32'd1);
        check("basic_first_addr", 32'(bus.out_addr), 32'h10000);
        check("basic_busy", 32'(busy), 32'd1);
        wait_done(30, c);
        check("basic_done_cycle", 32'(c), 32'd6);
        check("basic_hs", 32'(hs_count), 32'd6);
        check("basic_idx", 32'(frame_idx), 32'd1);
        check("basic_busy_end", 32'(busy), 32'd0);
        check("basic_q", 32'(exp_q.size()), 32'd0);

        // ring of three slots
        apply_reset();
        set_cfg(29'h10000, 8'd2, 1'b1, 12'd2);
        for (int f = 0; f < 4; f++) begin
            check("ring_idx", 32'(frame_idx), 32'(ring_idx[f]));
            push_frame(ring_base[f]);
            pulse_start();
            wait_done(30, c);
        end
        check("ring_q", 32'(exp_q.size()), 32'd0);

        // backpressure
        apply_reset();
        set_cfg(29'h10000, 8'd2, 1'b1, 12'd2);
        push_frame(29'h10000);
        hs_count = 0;
        bp_phase = 0;
        bp_ready = 1'b1;
        bp_mode = 1'b1;
        pulse_start();
        wait_done(60, c);
        bp_mode = 1'b0;
        check("bp_hs", 32'(hs_count), 32'd6);
        check("bp_q", 32'(exp_q.size()), 32'd0);

        // degenerate: nothing to issue
        apply_reset();
        set_cfg(29'h10000, 8'd0, 1'b0, 12'd2);
        hs_count = 0;
        pulse_start();
        wait_done(10, c);
        check("degen_done_cycle", 32'(c), 32'd1);
        check("degen_hs", 32'(hs_count), 32'd0);
        check("degen_idx", 32'(frame_idx), 32'd1);

        // tail-only lines
        apply_reset();
        set_cfg(29'h10000, 8'd0, 1'b1, 12'd2);
        push(1'b1, 29'h10000);
        push(1'b1, 29'h11000);
        pulse_start();
        wait_done(20, c);
        check("tailonly_q", 32'(exp_q.size()), 32'd0);

        // frame_start during ISSUE
        apply_reset();
        set_cfg(29'h10000, 8'd2, 1'b1, 12'd2);
        push_frame(29'h10000);
        hs_count = 0;
        pulse_start();
        tick();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clock);
        check("drop_pulse", 32'(frame_drop), 32'd1);
        wait_done(30, c);
        check("drop_hs", 32'(hs_count), 32'd6);
        check("drop_idx", 32'(frame_idx), 32'd1);
        check("drop_q", 32'(exp_q.size()), 32'd0);

        // abort after the third handshake, together with a frame_start
        apply_reset();
        set_cfg(29'h10000, 8'd2, 1'b1, 12'd2);
        push(1'b0, 29'h10000);
        push(1'b0, 29'h10100);
        push(1'b1, 29'h10200);
        hs_count = 0;
        pulse_start();
        tick();
        tick();
        tick();
        abort = 1'b1;
        frame_start = 1'b1;
        ready_drv = 1'b0;
        tick();
        abort = 1'b0;
        frame_start = 1'b0;
        ready_drv = 1'b1;
        @(negedge clock);
        check("abort_valid", 32'(bus.addr_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_drop", 32'(frame_drop), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        check("abort_idx", 32'(frame_idx), 32'd0);
        check("abort_hs", 32'(hs_count), 32'd3);
        check("abort_q", 32'(exp_q.size()), 32'd0);
        push_frame(29'h10000);
        hs_count = 0;
        pulse_start();
        @(negedge clock);
        check("restart_addr", 32'(bus.out_addr), 32'h10000);
        wait_done(30, c);
        check("restart_hs", 32'(hs_count), 32'd6);
        check("restart_idx", 32'(frame_idx), 32'd1);

        // address wrap modulo 2^29
        apply_reset();
        set_cfg(29'h1FFFFF80, 8'd2, 1'b0, 12'd1);
        push(1'b0, 29'h1FFFFF80);
        push(1'b0, 29'h00000080);
        pulse_start();
        wait_done(20, c);
        check("wrap_q", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-frame
        apply_reset();
        set_cfg(29'h10000, 8'd2, 1'b1, 12'd2);
        push_frame(29'h10000);
        pulse_start();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.addr_valid), 32'd0);
        check("arst_addr", 32'(bus.out_addr), 32'd0);
        check("arst_tail", 32'(bus.addr_is_tail), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        check("arst_pending", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clock);
        check("arst_after_valid", 32'(bus.addr_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdma_frame_addr_gen.md
Name: vdma_frame_addr_gen

Overview:
- Parametrised successor to the single-frame burst address counter in the address_ctrl group.
- Walks a ring of NFRAMES frame buffers. For each frame it issues one address per burst over lines_per_frame lines; each line is bursts_per_line full bursts plus an optional tail burst.
- Line start advances by a programmable line stride; frame base advances by a programmable frame stride.
- Addresses leave through a valid/ready handshake toward the AXI address channel, replacing the edge-detected request inputs of the previous generation.

Parameters:
- ASIZE, 29, address width (bytes).
- BURST_MAP_ADDR, 12800, byte offset between consecutive full bursts within a line.
- NFRAMES, 3, number of frame buffers in the ring (1..2^FSIZE).
- FSIZE, 2, width of frame_idx.
- LSIZE, 12, width of line counters.
- BSIZE, 8, width of burst-per-line counters.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse: begin a frame at the current ring slot.
- abort  in  1  synchronous abort of the frame in progress.
- frame_base  in  ASIZE  byte address of ring slot 0.
- frame_stride  in  ASIZE  byte offset between ring slots.
- line_stride  in  ASIZE  byte offset between line starts.
- bursts_per_line  in  BSIZE  full bursts per line.
- tail_en  in  1  one tail burst follows the full bursts on each line.
- lines_per_frame  in  LSIZE  lines per frame.
- out_addr  out  ASIZE  burst address.
- addr_valid  out  1  out_addr valid.
- addr_ready  in  1  consumer accepts out_addr.
- addr_is_tail  out  1  current address is a tail burst.
- frame_idx  out  FSIZE  ring slot of current/next frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame completion.
- frame_drop  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset values: out_addr=0, addr_valid=0, addr_is_tail=0, frame_idx=0, busy=0, frame_done=0, frame_drop=0. Internal frame pointer = 0, state IDLE.
- Config inputs (strides, counts, tail_en) are sampled only on an accepted frame_start; changes mid-frame have no effect.
- States: IDLE, ISSUE, FDONE.
- IDLE, frame_start=1: latch config; line_base = frame_ptr, where frame_ptr = frame_base when frame_idx=0, else the accumulated pointer.
  - If bursts_per_line=0 and tail_en=0, or lines_per_frame=0: go to FDONE; no address is issued.
  - Otherwise: go to ISSUE; busy=1; addr_valid=1 on the next cycle, so first address latency is 1 cycle.
- ISSUE:
  - out_addr and addr_is_tail hold stable while addr_valid=1 and addr_ready=0.
  - Each handshake (addr_valid & addr_ready) advances the position:
    - Next full burst: addr += BURST_MAP_ADDR.
    - Tail (addr_is_tail=1) at line_base + bursts_per_line*BURST_MAP_ADDR, reached by accumulation, no multiplier.
    - End of line: line_base += line_stride, and out_addr = new line_base.
  - Back-to-back handshakes are allowed: one address per cycle, addr_valid stays high.
  - After the last handshake of the last line: addr_valid=0 the next cycle, go to FDONE.
- FDONE (1 cycle):
  - frame_done=1.
  - frame_idx = (frame_idx==NFRAMES-1) ? 0 : frame_idx+1.
  - frame_ptr = frame_base when wrapping to 0, else frame_ptr + frame_stride.
  - busy=0 next cycle; return to IDLE. frame_start is accepted again in the cycle after FDONE.
- frame_start in ISSUE or FDONE is ignored and pulses frame_drop. Config and frame_idx are unchanged.
- abort (highest priority after reset):
  - Next cycle: addr_valid=0, busy=0, IDLE.
  - frame_idx and frame_ptr are unchanged, so the aborted slot is reused; no frame_done pulse.
  - abort and frame_start in the same cycle: abort wins; frame_start is neither started nor counted as a drop.
- All address sums wrap modulo 2^ASIZE, with no saturation or error.
- Asynchronous reset mid-frame: all state returns to reset values immediately; a pending address is discarded.

Test Plan:
- Basic walk: BURST_MAP_ADDR=0x100, base=0x10000, line_stride=0x1000, bursts=2, tail_en=1, lines=2, ready=1 -> addresses 0x10000, 0x10100, 0x10200(tail), 0x11000, 0x11100, 0x11200(tail) on consecutive cycles, first one cycle after frame_start; then frame_done=1 one cycle later and frame_idx=1.
- Ring: same config, frame_stride=0x40000, NFRAMES=3, four frames -> first addresses 0x10000, 0x50000, 0x90000, 0x10000; frame_idx sequence 0, 1, 2, 0.
- Backpressure: ready toggled 1,0,0,1,... -> out_addr and addr_is_tail stable while stalled; no address skipped or duplicated; 6 handshakes total.
- Degenerate config: bursts=0, tail_en=0 -> no addr_valid, frame_done two cycles after frame_start, frame_idx increments. Separately, bursts=0, tail_en=1 -> one tail address per line: 0x10000, 0x11000.
- Collisions: frame_start during ISSUE -> frame_drop pulse, sequence unaffected. abort after the third handshake -> addr_valid=0 next cycle, frame_idx unchanged, and the restarted frame begins at 0x10000.
- Wrap and reset: base=0x1FFFFF80 (ASIZE=29), bursts=2 -> addresses 0x1FFFFF80, 0x00000080. Assert rst_n low mid-frame -> all outputs 0 immediately.
